// File: rtl/prbs_pkg.sv
// Shared definitions for the framed PRBS source and its future receiver-side checker:
// polynomial encodings, tap constants, FSM states and LFSR helper functions.
package prbs_pkg;

    typedef enum logic [1:0] {
        POLY_PRBS7  = 2'd0,
        POLY_PRBS15 = 2'd1,
        POLY_PRBS23 = 2'd2,
        POLY_PRBS31 = 2'd3
    } poly_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int LFSR_W = 31;

    localparam int ORDER_PRBS7  = 7;
    localparam int ORDER_PRBS15 = 15;
    localparam int ORDER_PRBS23 = 23;
    localparam int ORDER_PRBS31 = 31;

    localparam int TAP_A_PRBS7  = 6;
    localparam int TAP_B_PRBS7  = 5;
    localparam int TAP_A_PRBS15 = 14;
    localparam int TAP_B_PRBS15 = 13;
    localparam int TAP_A_PRBS23 = 22;
    localparam int TAP_B_PRBS23 = 17;
    localparam int TAP_A_PRBS31 = 30;
    localparam int TAP_B_PRBS31 = 27;

    // All-ones never locks up an XOR-feedback LFSR.
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 31'h7FFF_FFFF;

    function automatic logic [LFSR_W-1:0] poly_mask(input poly_sel_e p);
        case (p)
            POLY_PRBS7:  poly_mask = DEFAULT_SEED >> (LFSR_W - ORDER_PRBS7);
            POLY_PRBS15: poly_mask = DEFAULT_SEED >> (LFSR_W - ORDER_PRBS15);
            POLY_PRBS23: poly_mask = DEFAULT_SEED >> (LFSR_W - ORDER_PRBS23);
            default:     poly_mask = DEFAULT_SEED >> (LFSR_W - ORDER_PRBS31);
        endcase
    endfunction

    function automatic logic lfsr_feedback(input poly_sel_e p, input logic [LFSR_W-1:0] s);
        case (p)
            POLY_PRBS7:  lfsr_feedback = s[TAP_A_PRBS7]  ^ s[TAP_B_PRBS7];
            POLY_PRBS15: lfsr_feedback = s[TAP_A_PRBS15] ^ s[TAP_B_PRBS15];
            POLY_PRBS23: lfsr_feedback = s[TAP_A_PRBS23] ^ s[TAP_B_PRBS23];
            default:     lfsr_feedback = s[TAP_A_PRBS31] ^ s[TAP_B_PRBS31];
        endcase
    endfunction

    function automatic logic [LFSR_W-1:0] seed_fix(input poly_sel_e p, input logic [LFSR_W-1:0] seed);
        logic [LFSR_W-1:0] m;
        m = poly_mask(p);
        if ((seed & m) == 31'd0) begin
            seed_fix = DEFAULT_SEED & m;
        end else begin
            seed_fix = seed & m;
        end
    endfunction

endpackage

// File: rtl/prbs_frame_source_if.sv
// AXI-Stream beat channel between the PRBS frame source and its consumer.
interface prbs_frame_source_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tuser;

    modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/prbs_lfsr_par.sv
// Fibonacci LFSR (up to 31 bits) advancing DATA_WIDTH bits per step; the first
// generated bit lands in the word MSB.
module prbs_lfsr_par
    import prbs_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [LFSR_W-1:0]     i_seed,
    input  logic                  i_advance,
    input  poly_sel_e             i_poly,
    output logic [DATA_WIDTH-1:0] o_word
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;
    logic [LFSR_W-1:0] step_s;

    // Unrolled DATA_WIDTH single-bit steps from the current state.
    always_comb begin
        logic [LFSR_W-1:0] s;
        logic              fb;
        s      = state_q;
        fb     = 1'b0;
        o_word = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            fb = lfsr_feedback(i_poly, s);
            s  = {s[LFSR_W-2:0], fb} & poly_mask(i_poly);
            o_word[DATA_WIDTH-1-i] = fb;
        end
        step_s = s;
    end

    // Load has priority over advance.
    always_comb begin
        if (i_load) begin
            state_d = i_seed;
        end else if (i_advance) begin
            state_d = step_s;
        end else begin
            state_d = state_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/prbs_frame_source.sv
// Framed PRBS AXI-Stream master: selectable polynomial, frame length, inter-frame gap,
// frame count and graceful stop, with lossless back-pressure.
module prbs_frame_source
    import prbs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [1:0]            i_poly_sel,
    input  logic [LFSR_W-1:0]     i_seed,
    input  logic [LEN_WIDTH-1:0]  i_frame_len,
    input  logic [LEN_WIDTH-1:0]  i_gap_cycles,
    input  logic [CNT_WIDTH-1:0]  i_frame_count,
    prbs_frame_source_if.master   m_axis,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_cfg_err,
    output logic [CNT_WIDTH-1:0]  o_frames_sent
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic                  tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [CNT_WIDTH-1:0]  frames_sent_q, frames_sent_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [LEN_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic                  stop_pend_q, stop_pend_d;
    poly_sel_e             poly_q, poly_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  gap_q, gap_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    logic                  load_beat_s;
    logic                  lfsr_adv_s;
    logic                  lfsr_load_s;
    logic [LFSR_W-1:0]     lfsr_seed_s;
    logic [DATA_WIDTH-1:0] lfsr_word_s;
    logic [CNT_WIDTH-1:0]  sent_inc_s;
    logic [LEN_WIDTH-1:0]  len_last_s;
    logic                  run_end_s;

    prbs_lfsr_par #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lfsr (
        .clk       (s_axi_aclk),
        .rst_n     (s_axi_aresetn),
        .i_load    (lfsr_load_s),
        .i_seed    (lfsr_seed_s),
        .i_advance (lfsr_adv_s),
        .i_poly    (poly_q),
        .o_word    (lfsr_word_s)
    );

    // Next-state, beat loading and status pulses.
    always_comb begin
        state_d       = state_q;
        tvalid_d      = tvalid_q;
        tdata_d       = tdata_q;
        tlast_d       = tlast_q;
        tuser_d       = tuser_q;
        frames_sent_d = frames_sent_q;
        beat_d        = beat_q;
        gap_cnt_d     = gap_cnt_q;
        stop_pend_d   = stop_pend_q;
        poly_d        = poly_q;
        len_d         = len_q;
        gap_d         = gap_q;
        count_d       = count_q;
        cfg_err_d     = 1'b0;
        lfsr_load_s   = 1'b0;
        load_beat_s   = 1'b0;
        lfsr_adv_s    = 1'b0;
        lfsr_seed_s   = seed_fix(poly_sel_e'(i_poly_sel), i_seed);
        sent_inc_s    = frames_sent_q + CNT_ONE;
        len_last_s    = len_q - LEN_ONE;
        run_end_s     = ((count_q != '0) && (sent_inc_s == count_q)) || stop_pend_q || i_stop;

        case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (i_start && (i_frame_len == '0)) begin
                    cfg_err_d = 1'b1;
                end else if (i_start) begin
                    poly_d        = poly_sel_e'(i_poly_sel);
                    len_d         = i_frame_len;
                    gap_d         = i_gap_cycles;
                    count_d       = i_frame_count;
                    lfsr_load_s   = 1'b1;
                    frames_sent_d = '0;
                    beat_d        = '0;
                    state_d       = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                stop_pend_d = stop_pend_q | i_stop;
                if (tvalid_q && !m_axis.tready) begin
                    load_beat_s = 1'b0;
                end else if (tvalid_q && tlast_q) begin
                    frames_sent_d = (frames_sent_q == '1) ? frames_sent_q : sent_inc_s;
                    if (run_end_s) begin
                        tvalid_d = 1'b0;
                        state_d  = ST_DONE;
                    end else if (gap_q != '0) begin
                        tvalid_d  = 1'b0;
                        gap_cnt_d = gap_q;
                        state_d   = ST_GAP;
                    end else begin
                        load_beat_s = 1'b1;
                    end
                end else begin
                    load_beat_s = 1'b1;
                end
            end
            ST_GAP: begin
                stop_pend_d = stop_pend_q | i_stop;
                // The next frame's first beat is loaded on the last gap cycle so tvalid
                // stays low for exactly the programmed number of cycles.
                if (stop_pend_q || i_stop) begin
                    state_d = ST_DONE;
                end else if (gap_cnt_q == LEN_ONE) begin
                    load_beat_s = 1'b1;
                    state_d     = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - LEN_ONE;
                end
            end
            ST_DONE: begin
                stop_pend_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_beat_s) begin
            lfsr_adv_s = 1'b1;
            tvalid_d   = 1'b1;
            tdata_d    = lfsr_word_s;
            tuser_d    = (beat_q == '0);
            tlast_d    = (beat_q == len_last_s);
            beat_d     = (beat_q == len_last_s) ? '0 : (beat_q + LEN_ONE);
        end else begin
            lfsr_adv_s = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q       <= ST_IDLE;
            tvalid_q      <= 1'b0;
            tdata_q       <= '0;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            frames_sent_q <= '0;
            beat_q        <= '0;
            gap_cnt_q     <= '0;
            stop_pend_q   <= 1'b0;
            poly_q        <= POLY_PRBS7;
            len_q         <= '0;
            gap_q         <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            tvalid_q      <= tvalid_d;
            tdata_q       <= tdata_d;
            tlast_q       <= tlast_d;
            tuser_q       <= tuser_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cfg_err_q     <= cfg_err_d;
            frames_sent_q <= frames_sent_d;
            beat_q        <= beat_d;
            gap_cnt_q     <= gap_cnt_d;
            stop_pend_q   <= stop_pend_d;
            poly_q        <= poly_d;
            len_q         <= len_d;
            gap_q         <= gap_d;
            count_q       <= count_d;
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tuser  = tuser_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_cfg_err     = cfg_err_q;
    assign o_frames_sent = frames_sent_q;

endmodule

// File: doc/prbs_frame_source.md
Name: prbs_frame_source

Overview:
Parametrised, framed PRBS stream generator. It replaces the fixed free-running PRBS-to-stream path in the transmitter with selectable polynomial, configurable data width, frame length, inter-frame gap and frame count. It is a proper AXI-Stream master: SOF on tuser, EOF on tlast, and lossless back-pressure. It sits between the transmitter AXI-Lite register block (config/status ports) and the downstream encryption datapath.

Parameters:
DATA_WIDTH, 32, tdata width in bits; multiple of 8, range 8..64.
LEN_WIDTH, 16, width of frame-length and gap fields.
CNT_WIDTH, 16, width of frame-count field and frames-sent counter.

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  reset, asynchronous, active-low
i_start  in  1  single-cycle start pulse from register block
i_stop  in  1  single-cycle graceful-stop request
i_poly_sel  in  2  0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31
i_seed  in  31  LFSR seed; low bits used for shorter polynomials
i_frame_len  in  LEN_WIDTH  beats per frame; 0 is illegal
i_gap_cycles  in  LEN_WIDTH  idle cycles between frames
i_frame_count  in  CNT_WIDTH  frames to send; 0 = continuous
m_axis_tready  in  1  downstream ready
m_axis_tvalid  out  1  beat valid
m_axis_tdata  out  DATA_WIDTH  PRBS data
m_axis_tlast  out  1  last beat of frame
m_axis_tuser  out  1  first beat of frame (SOF)
o_busy  out  1  FSM not IDLE
o_done  out  1  one-cycle pulse on run completion
o_cfg_err  out  1  one-cycle pulse when start is rejected
o_frames_sent  out  CNT_WIDTH  frames completed since last start; saturates

Behaviour:
- Reset: all outputs 0; FSM = IDLE; LFSR = 0. Reset asserted mid-frame drops tvalid immediately; no completion of the frame.
- LFSR: Fibonacci; per bit new = s[a]^s[b], s = {s, new} truncated to the polynomial order. Taps (0-based) are PRBS7 6,5; PRBS15 14,13; PRBS23 22,17; PRBS31 30,27. Advances DATA_WIDTH bits per beat; the first generated bit goes to tdata MSB. A seed whose used bits are all zero is replaced by all-ones.
- Config (poly, seed, len, gap, count) is latched on an accepted start. Later input changes are ignored until the next start.
- i_start in IDLE with i_frame_len==0: o_cfg_err pulses next cycle and the FSM stays in IDLE. i_start while busy: ignored.
- FSM states:
  - IDLE: on a valid start, load the LFSR, clear o_frames_sent, go to SEND.
  - SEND: drive beats.
  - GAP: count down the latched gap.
  - DONE: one cycle; pulse o_done, then IDLE.
- Latency: start sampled at edge N; tvalid high after edge N+1, carrying the first word.
- Handshake: the next beat is loaded only when !tvalid || tready. While tvalid && !tready, tdata/tlast/tuser hold stable. tvalid never drops without a transfer, except on reset.
- Beat counter: tuser=1 on beat 0; tlast=1 on beat len-1. For len==1, tuser and tlast are both 1 on the same beat.
- On the accepted tlast beat:
  - o_frames_sent increments, saturating at all-ones.
  - Run ends (go to DONE) if (count!=0 && frames_sent+1==count) or a stop is pending.
  - Otherwise go to GAP if gap!=0, else emit the next frame's beat 0 back-to-back on the following cycle.
- GAP: tvalid=0 for exactly gap cycles, then SEND.
- LFSR continues across frames; it is not reseeded per frame.
- i_stop: sets a pending flag in SEND/GAP, cleared at IDLE.
  - In SEND: the current frame completes, then DONE.
  - In GAP: go to DONE next cycle.
  - In IDLE: no effect.
- Simultaneous i_start and i_stop in IDLE: start wins; the stop is discarded.

Decomposition:
- Package prbs_pkg:
  - poly_sel encodings and per-polynomial order/tap constants;
  - FSM state enum {IDLE, SEND, GAP, DONE};
  - lock-up-free default seed.
- Sub-module prbs_lfsr_par:
  - registered 31-bit state with load/advance inputs;
  - combinational DATA_WIDTH-bit parallel step;
  - shared with the future receiver-side checker.

Test Plan:
- DATA_WIDTH=8, PRBS7, seed 0x7F, len 4, gap 0, count 1, tready=1 -> beat 0 tdata=0x02 with tuser=1; beats 1-3 match the reference model; tlast on beat 3; o_done pulses; o_frames_sent=1.
- len 1, count 3, gap 2 -> three single beats, each with tuser=tlast=1, separated by exactly 2 idle cycles; o_frames_sent=3.
- PRBS31, len 8, tready toggled pseudo-randomly -> tdata/tlast/tuser stable while stalled; 8 accepted beats equal the unstalled reference sequence.
- count 0, len 5, i_stop asserted on beat 2 of frame 4 -> frame 4 completes; o_done pulses; o_frames_sent=4; no further beats.
- i_frame_len=0 with start -> o_cfg_err pulse; o_busy stays 0; no tvalid. Seed 0 with PRBS15 -> output identical to seed 0x7FFF.
- Reset asserted mid-frame -> all outputs 0 immediately; after release a new start runs normally from beat 0.
